// File: rtl/audio_pkg.sv
// Shared widths, constants and types for the stereo delta-sigma DAC.
// Dither LFSR constants are only consumed when AUDIO_DSM_DITHER_EN is defined.
package audio_pkg;

    localparam int unsigned AUDIO_W           = 16;
    localparam int unsigned AUDIO_INTERP_LOG2 = 9;
    localparam logic [AUDIO_W-1:0] AUDIO_MIDSCALE = 16'h8000;

    typedef logic [AUDIO_W-1:0]        audio_sample_t;
    typedef logic signed [AUDIO_W:0]   audio_step_t;

    typedef enum logic {StIdle, StRamp} ramp_state_t;

    localparam logic [15:0] AUDIO_LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of taps 16,14,13,11
    localparam logic [15:0] AUDIO_LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {1'b0, state[15:1]} ^ (state[0] ? AUDIO_LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/dsm1_channel.sv
// One DAC channel: target/current level with linear ramp, plus a first-order
// delta-sigma modulator whose carry-out is the one-bit output.
module dsm1_channel #(
    parameter int unsigned W           = 16,
    parameter int unsigned INTERP_LOG2 = 9
) (
    input  logic         clk24,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_target,
    input  logic         i_ramp_act,
    input  logic         i_ramp_last,
    input  logic [2:0]   i_dither,
    output logic         o_dsm
);

    localparam logic [W-1:0] MIDSCALE = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]        r_target;
    logic [W-1:0]        r_cur;
    logic [W-1:0]        r_acc;
    logic signed [W:0]   r_step;
    logic                r_dsm;

    logic signed [W:0]   w_diff;
    logic signed [W:0]   w_step;
    logic signed [W:0]   w_cur_next;
    logic [W+1:0]        w_sum;

    assign w_diff     = $signed({1'b0, i_target}) - $signed({1'b0, r_cur});
    assign w_step     = w_diff >>> INTERP_LOG2;
    assign w_cur_next = $signed({1'b0, r_cur}) + r_step;
    // Extra top bit only matters when dither pushes the sum past 2**(W+1)
    assign w_sum      = {2'b00, r_acc} + {2'b00, r_cur} + {{(W-1){1'b0}}, i_dither};

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            r_target <= MIDSCALE;
            r_cur    <= MIDSCALE;
            r_step   <= '0;
        end else if (i_load) begin
            r_target <= i_target;
            r_step   <= w_step;
        end else if (i_ramp_last) begin
            r_cur    <= r_target;
        end else if (i_ramp_act) begin
            r_cur    <= w_cur_next[W-1:0];
        end
    end

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_dsm <= 1'b0;
        end else begin
            r_acc <= w_sum[W-1:0];
            r_dsm <= |w_sum[W+1:W];
        end
    end

    assign o_dsm = r_dsm;

endmodule

// File: rtl/audio_dsm_dac.sv
// Stereo first-order delta-sigma DAC with linear inter-sample ramping and mute.
// Define AUDIO_DSM_DITHER_EN to add a 3-bit LFSR dither into both modulators.
module audio_dsm_dac
    import audio_pkg::*;
#(
    parameter int unsigned W           = AUDIO_W,
    parameter int unsigned INTERP_LOG2 = AUDIO_INTERP_LOG2
) (
    input  logic         clk24,
    input  logic         reset_n,
    input  logic         i_sample_ce,
    input  logic [W-1:0] i_sample_l,
    input  logic [W-1:0] i_sample_r,
    input  logic         i_mute,
    output logic         o_dsm_l,
    output logic         o_dsm_r,
    output logic         o_ramping
);

    localparam logic [W-1:0] MIDSCALE = {1'b1, {(W-1){1'b0}}};

    ramp_state_t              r_state;
    logic [INTERP_LOG2-1:0]   r_ramp_cnt;
    logic                     r_ramping;
    logic                     r_mute_q;

    logic                     w_mute_rise;
    logic                     w_load;
    logic                     w_ramp_act;
    logic                     w_ramp_last;
    logic [W-1:0]             w_tgt_l;
    logic [W-1:0]             w_tgt_r;
    logic [2:0]               w_dither;

    assign w_mute_rise = i_mute & ~r_mute_q;
    assign w_load      = w_mute_rise | (i_sample_ce & ~i_mute);
    assign w_tgt_l     = w_mute_rise ? MIDSCALE : i_sample_l;
    assign w_tgt_r     = w_mute_rise ? MIDSCALE : i_sample_r;
    assign w_ramp_act  = (r_ramp_cnt != '0);
    assign w_ramp_last = (r_ramp_cnt == INTERP_LOG2'(1));

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            r_mute_q <= 1'b0;
        end else begin
            r_mute_q <= i_mute;
        end
    end

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_ramp_cnt <= '0;
            r_ramping  <= 1'b0;
        end else if (w_load) begin
            r_state    <= StRamp;
            r_ramp_cnt <= '1;
            r_ramping  <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_ramping <= 1'b0;
                end
                StRamp: begin
                    r_ramp_cnt <= r_ramp_cnt - INTERP_LOG2'(1);
                    if (w_ramp_last) begin
                        r_state   <= StIdle;
                        r_ramping <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef AUDIO_DSM_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= AUDIO_LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_dither = r_lfsr[2:0];
`else
    assign w_dither = 3'b000;
`endif

    dsm1_channel #(
        .W           (W),
        .INTERP_LOG2 (INTERP_LOG2)
    ) u_ch_l (
        .clk24       (clk24),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_target    (w_tgt_l),
        .i_ramp_act  (w_ramp_act),
        .i_ramp_last (w_ramp_last),
        .i_dither    (w_dither),
        .o_dsm       (o_dsm_l)
    );

    dsm1_channel #(
        .W           (W),
        .INTERP_LOG2 (INTERP_LOG2)
    ) u_ch_r (
        .clk24       (clk24),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_target    (w_tgt_r),
        .i_ramp_act  (w_ramp_act),
        .i_ramp_last (w_ramp_last),
        .i_dither    (w_dither),
        .o_dsm       (o_dsm_r)
    );

    assign o_ramping = r_ramping;

endmodule

// File: tb/tb_audio_dsm_dac.sv
// Directed self-checking bench for audio_dsm_dac: reset, ramp timing, retarget,
// mute, async reset and exact bitstream density.
module tb_audio_dsm_dac;

    logic        clk24 = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_sample_ce = 1'b0;
    logic [15:0] i_sample_l = 16'h0000;
    logic [15:0] i_sample_r = 16'h0000;
    logic        i_mute = 1'b0;
    logic        o_dsm_l;
    logic        o_dsm_r;
    logic        o_ramping;

    int n_checks = 0;
    int n_fail   = 0;

    // Continuity monitor on the left level
    logic        mon_en = 1'b0;
    int          max_delta = 0;
    int          prev_cur = 0;

    always #5 clk24 = ~clk24;

    audio_dsm_dac u_dut (
        .clk24       (clk24),
        .reset_n     (reset_n),
        .i_sample_ce (i_sample_ce),
        .i_sample_l  (i_sample_l),
        .i_sample_r  (i_sample_r),
        .i_mute      (i_mute),
        .o_dsm_l     (o_dsm_l),
        .o_dsm_r     (o_dsm_r),
        .o_ramping   (o_ramping)
    );

    always @(negedge clk24) begin
        int cur;
        int d;
        cur = int'(u_dut.u_ch_l.r_cur);
        d = (cur > prev_cur) ? cur - prev_cur : prev_cur - cur;
        if (mon_en && d > max_delta) max_delta = d;
        prev_cur = cur;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk24);
        i_sample_ce = 1'b1;
        i_sample_l  = l;
        i_sample_r  = r;
        @(negedge clk24);
        i_sample_ce = 1'b0;
    endtask

    // Counts clock edges from the loading edge to the edge that drops o_ramping
    task automatic ramp_len(output int n);
        n = 1;
        while (o_ramping === 1'b1 && n < 2000) begin
            @(negedge clk24);
            n++;
        end
    endtask

    task automatic count_ones(input int cycles, output int ones_l, output int ones_r);
        ones_l = 0;
        ones_r = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk24);
            ones_l += int'(o_dsm_l);
            ones_r += int'(o_dsm_r);
        end
    endtask

    initial begin
        int n;
        int ol;
        int orr;

        // 1: reset state and midscale alternation
        repeat (3) @(negedge clk24);
        check_eq("rst_ramping", o_ramping, 0);
        check_eq("rst_dsm_l", o_dsm_l, 0);
        check_eq("rst_cur_l", u_dut.u_ch_l.r_cur, 32'h8000);
        check_eq("rst_cur_r", u_dut.u_ch_r.r_cur, 32'h8000);
        reset_n = 1'b1;
`ifndef AUDIO_DSM_DITHER_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clk24);
            check_eq($sformatf("alt_l_%0d", i), o_dsm_l, i % 2);
            check_eq($sformatf("alt_r_%0d", i), o_dsm_r, i % 2);
        end
`endif

        // 2: full-scale ramps
        strobe(16'h0000, 16'hFFFF);
        ramp_len(n);
        check_eq("ramp_len_fs", n, 512);
        check_eq("cur_l_zero", u_dut.u_ch_l.r_cur, 32'h0000);
        check_eq("cur_r_full", u_dut.u_ch_r.r_cur, 32'hFFFF);
        repeat (3) @(negedge clk24);
`ifndef AUDIO_DSM_DITHER_EN
        count_ones(1024, ol, orr);
        check_eq("zero_const_l", ol, 0);
`endif

        // Retarget L, R unchanged: step 0 but ramp still runs
        strobe(16'h1000, 16'hFFFF);
        check_eq("ramp_on_equal", o_ramping, 1);
        ramp_len(n);
        check_eq("ramp_len_eq", n, 512);
        check_eq("cur_l_1000", u_dut.u_ch_l.r_cur, 32'h1000);
        check_eq("cur_r_hold", u_dut.u_ch_r.r_cur, 32'hFFFF);
        repeat (3) @(negedge clk24);

        // 6 (and 2): exact density over one full period
        count_ones(65536, ol, orr);
`ifndef AUDIO_DSM_DITHER_EN
        check_eq("dens_l_1000", ol, 4096);
        check_eq("dens_r_ffff", orr, 65535);
`else
        check_eq("dens_l_dither", (ol >= 4088 && ol <= 4104), 1);
`endif

        // 3: retarget mid-ramp
        max_delta = 0;
        mon_en = 1'b1;
        strobe(16'h4000, 16'h4000);
        repeat (199) @(negedge clk24);
        check_eq("mid_ramp_active", o_ramping, 1);
        strobe(16'hC000, 16'hC000);
        ramp_len(n);
        repeat (2) @(negedge clk24);
        mon_en = 1'b0;
        check_eq("ramp_len_retgt", n, 512);
        check_eq("cur_l_c000", u_dut.u_ch_l.r_cur, 32'hC000);
        check_eq("cur_r_c000", u_dut.u_ch_r.r_cur, 32'hC000);
        check_eq("no_jump", (max_delta > 0 && max_delta <= 32'h400), 1);

        // 4: mute
        @(negedge clk24);
        i_mute = 1'b1;
        @(negedge clk24);
        ramp_len(n);
        check_eq("ramp_len_mute", n, 512);
        check_eq("cur_l_mute", u_dut.u_ch_l.r_cur, 32'h8000);
        for (int i = 0; i < 3; i++) begin
            strobe(16'hFFFF, 16'hFFFF);
            check_eq($sformatf("mute_ign_ramp_%0d", i), o_ramping, 0);
        end
        repeat (5) @(negedge clk24);
        check_eq("mute_ign_cur", u_dut.u_ch_l.r_cur, 32'h8000);
        i_mute = 1'b0;
        repeat (10) @(negedge clk24);
        check_eq("unmute_wait_ramp", o_ramping, 0);
        check_eq("unmute_wait_cur", u_dut.u_ch_r.r_cur, 32'h8000);
        strobe(16'h2000, 16'h2000);
        ramp_len(n);
        check_eq("ramp_len_unmute", n, 512);
        check_eq("cur_l_2000", u_dut.u_ch_l.r_cur, 32'h2000);

        // 5: async reset mid-ramp
        strobe(16'hF000, 16'h0100);
        repeat (100) @(negedge clk24);
        check_eq("pre_rst_ramping", o_ramping, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_ramping", o_ramping, 0);
        check_eq("arst_dsm_l", o_dsm_l, 0);
        check_eq("arst_dsm_r", o_dsm_r, 0);
        @(negedge clk24);
        reset_n = 1'b1;
        repeat (4) @(negedge clk24);
        check_eq("post_rst_cur_l", u_dut.u_ch_l.r_cur, 32'h8000);
        check_eq("post_rst_cur_r", u_dut.u_ch_r.r_cur, 32'h8000);
        check_eq("post_rst_ramping", o_ramping, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
